hazard_fwd_unit: RTL



---
 rtl/hazard_fwd_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
//
// Hazard-detection and forwarding unit for the pipelined TSC core. It sits
// beside the ID/EX pipeline register and keeps a short shift-register
// scoreboard of the instructions that have already entered EX. For the
// instruction currently in ID it looks for producers of its source operands:
//   - stall:      the youngest producer is a load whose data cannot be
//                 forwarded yet, so PC and IF/ID hold and a bubble enters EX
//   - fwd_a/fwd_b: registered operand-source selects that the consumer sees
//                 during its EX cycle (0 = register file, s = post-EX stage s)
//
// Parameters:
//   REG_ADDR_W  register address width
//   FWD_DEPTH   number of post-EX stages that can forward (1..7)
//   LOAD_LAT    extra stages before load data is forwardable (0..FWD_DEPTH-1)
//   FWD_SEL_W   select width, derived from FWD_DEPTH
//
// Ports:
//   clk            core clock, rising edge
//   reset_n        asynchronous active-low reset
//   id_valid       ID holds a real instruction
//   id_rs1/id_rs2  ID source registers
//   id_use_rs1/2   the corresponding operand is actually read
//   id_rd          ID destination register
//   id_reg_write   ID instruction writes id_rd
//   id_mem_read    ID instruction is a load
//   ex_flush       taken branch/jump in EX; kills the ID instruction
//   stall          combinational load-use stall request
//   fwd_a/fwd_b    forwarding selects for the instruction in EX
//   perf_stall_cnt saturating count of stall cycles
//
// Optional feature macro: HAZARD_STALL_CNT_EN
//   defined     -> perf_stall_cnt port and counter are present
//   not defined -> no port, no counter logic
// ---------------------------------------------------------------------------
module hazard_fwd_unit #(
  parameter int REG_ADDR_W = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  parameter int FWD_SEL_W  = $clog2(FWD_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_flush,
  output logic                  stall,
  output logic [FWD_SEL_W-1:0]  fwd_a,
  output logic [FWD_SEL_W-1:0]  fwd_b
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [15:0]           perf_stall_cnt
`endif
);

  // Scoreboard: entry 0 is the instruction in EX, entry j is j stages later.
  logic [FWD_DEPTH-1:0]  sb_valid;
  logic [FWD_DEPTH-1:0]  sb_reg_write;
  logic [FWD_DEPTH-1:0]  sb_mem_read;
  logic [REG_ADDR_W-1:0] sb_rd [FWD_DEPTH];

  logic [FWD_SEL_W-1:0]  sel_a;
  logic [FWD_SEL_W-1:0]  sel_b;
  logic                  hazard_a;
  logic                  hazard_b;
  logic                  advance;

  // Youngest-match search. Scanning from the oldest entry towards entry 0
  // lets the last hit (smallest j) overwrite older ones. A load match only
  // raises a hazard while it is still closer to EX than LOAD_LAT stages.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
      if (sb_valid[j] && sb_reg_write[j] && id_use_rs1 && (sb_rd[j] == id_rs1)) begin
        sel_a    = FWD_SEL_W'(j + 1);
        hazard_a = sb_mem_read[j] && (j < LOAD_LAT);
      end
      if (sb_valid[j] && sb_reg_write[j] && id_use_rs2 && (sb_rd[j] == id_rs2)) begin
        sel_b    = FWD_SEL_W'(j + 1);
        hazard_b = sb_mem_read[j] && (j < LOAD_LAT);
      end
    end
  end

  // A flush wins over a stall: the ID instruction is dropped anyway, so
  // holding it would only waste a cycle.
  assign stall   = id_valid && !ex_flush && (hazard_a || hazard_b);
  assign advance = id_valid && !stall && !ex_flush;

  // Scoreboard shift. Downstream stages never stall, so older entries move
  // every cycle; entry 0 takes the ID instruction or a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_valid     <= '0;
      sb_reg_write <= '0;
      sb_mem_read  <= '0;
      for (int j = 0; j < FWD_DEPTH; j++) begin
        sb_rd[j] <= '0;
      end
    end else begin
      for (int j = 1; j < FWD_DEPTH; j++) begin
        sb_valid[j]     <= sb_valid[j-1];
        sb_reg_write[j] <= sb_reg_write[j-1];
        sb_mem_read[j]  <= sb_mem_read[j-1];
        sb_rd[j]        <= sb_rd[j-1];
      end
      if (advance) begin
        sb_valid[0]     <= 1'b1;
        sb_reg_write[0] <= id_reg_write;
        sb_mem_read[0]  <= id_mem_read;
        sb_rd[0]        <= id_rd;
      end else begin
        sb_valid[0]     <= 1'b0;
        sb_reg_write[0] <= 1'b0;
        sb_mem_read[0]  <= 1'b0;
        sb_rd[0]        <= '0;
      end
    end
  end

  // Forwarding selects are registered alongside the instruction entering EX;
  // a bubble always reads from the register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_a <= '0;
      fwd_b <= '0;
    end else if (advance) begin
      fwd_a <= sel_a;
      fwd_b <= sel_b;
    end else begin
      fwd_a <= '0;
      fwd_b <= '0;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // Saturating stall-cycle counter; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
    end else if (stall && (perf_stall_cnt != 16'hFFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
